// File: rtl/bus_interconnect.sv
// Fixed-priority req/gnt/rvalid crossbar: the lowest-index requesting host is granted
// and routed to the lowest-index device whose base/mask matches; responses return one cycle later.
module bus_interconnect #(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      host_req_i     [NrHosts],
  output logic                      host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
  input  logic                      host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
  output logic                      host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],
  output logic                      host_err_o     [NrHosts],

  output logic                      device_req_o   [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
  output logic                      device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic                      device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic                      device_err_i   [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned BeW      = DataWidth / 8;

  logic                    w_host_valid;
  logic [HostIdxW-1:0]     w_host_sel;
  logic [AddressWidth-1:0] w_addr;
  logic                    w_we;
  logic [BeW-1:0]          w_be;
  logic [DataWidth-1:0]    w_wdata;
  logic                    w_dev_hit;
  logic [DevIdxW-1:0]      w_dev_sel;

  logic                    r_rsp_pending;
  logic [HostIdxW-1:0]     r_host_sel;
  logic [DevIdxW-1:0]      r_dev_sel;
  logic                    r_unmapped;

  // Scanning from the top index down lets the lowest-index requester overwrite the rest.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    w_host_valid = 1'b0;
    w_host_sel   = '0;
    w_addr       = '0;
    w_we         = 1'b0;
    w_be         = '0;
    w_wdata      = '0;
    for (int i = int'(NrHosts) - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        w_host_valid = 1'b1;
        w_host_sel   = HostIdxW'(i);
        w_addr       = host_addr_i[i];
        w_we         = host_we_i[i];
        w_be         = host_be_i[i];
        w_wdata      = host_wdata_i[i];
      end
    end
  end

  always_comb begin
    w_dev_hit = 1'b0;
    w_dev_sel = '0;
    for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
      if ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        w_dev_hit = 1'b1;
        w_dev_sel = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_gnt_o[h] = w_host_valid && (w_host_sel == HostIdxW'(h));
    end
    for (int d = 0; d < int'(NrDevices); d++) begin
      device_req_o[d]   = w_host_valid && w_dev_hit && (w_dev_sel == DevIdxW'(d));
      device_addr_o[d]  = w_addr;
      device_we_o[d]    = w_we;
      device_be_o[d]    = w_be;
      device_wdata_o[d] = w_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_pending <= 1'b0;
      r_host_sel    <= '0;
      r_dev_sel     <= '0;
      r_unmapped    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_rsp_pending <= w_host_valid;
      r_host_sel    <= w_host_sel;
      r_dev_sel     <= w_dev_sel;
      r_unmapped    <= w_host_valid && !w_dev_hit;
    end
  end

  // Unmapped accesses are answered locally with an error and zero data.
  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (r_rsp_pending && (r_host_sel == HostIdxW'(h))) begin
        if (r_unmapped) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
          host_rvalid_o[h] = device_rvalid_i[r_dev_sel];
          host_rdata_o[h]  = device_rdata_i[r_dev_sel];
          host_err_o[h]    = device_err_i[r_dev_sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect with 2 hosts and 3 devices; responses are
// checked by a negedge monitor against a queue of hand-computed expectations.
module tb_bus_interconnect;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        host_req    [2];
  logic        host_gnt    [2];
  logic [31:0] host_addr   [2];
  logic        host_we     [2];
  logic [3:0]  host_be     [2];
  logic [31:0] host_wdata  [2];
  logic        host_rvalid [2];
  logic [31:0] host_rdata  [2];
  logic        host_err    [2];

  logic        device_req    [3];
  logic [31:0] device_addr   [3];
  logic        device_we     [3];
  logic [3:0]  device_be     [3];
  logic [31:0] device_wdata  [3];
  logic        device_rvalid [3];
  logic [31:0] device_rdata  [3];
  logic        device_err    [3];
  logic [31:0] cfg_base      [3];
  logic [31:0] cfg_mask      [3];

  bus_interconnect #(
    .NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .host_req_i          (host_req),
    .host_gnt_o          (host_gnt),
    .host_addr_i         (host_addr),
    .host_we_i           (host_we),
    .host_be_i           (host_be),
    .host_wdata_i        (host_wdata),
    .host_rvalid_o       (host_rvalid),
    .host_rdata_o        (host_rdata),
    .host_err_o          (host_err),
    .device_req_o        (device_req),
    .device_addr_o       (device_addr),
    .device_we_o         (device_we),
    .device_be_o         (device_be),
    .device_wdata_o      (device_wdata),
    .device_rvalid_i     (device_rvalid),
    .device_rdata_i      (device_rdata),
    .device_err_i        (device_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  logic [1:0] gnt_v, rvalid_v, err_v;
  logic [2:0] dreq_v;
  assign gnt_v    = {host_gnt[1], host_gnt[0]};
  assign rvalid_v = {host_rvalid[1], host_rvalid[0]};
  assign err_v    = {host_err[1], host_err[0]};
  assign dreq_v   = {device_req[2], device_req[1], device_req[0]};

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input int host, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.host  = host;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic host_drive(input int h, input logic req, input logic [31:0] addr,
                            input logic we, input logic [3:0] be, input logic [31:0] wdata);
    host_req[h]   = req;
    host_addr[h]  = addr;
    host_we[h]    = we;
    host_be[h]    = be;
    host_wdata[h] = wdata;
  endtask

  task automatic dev_drive(input int d, input logic rvalid, input logic [31:0] rdata,
                           input logic err);
    device_rvalid[d] = rvalid;
    device_rdata[d]  = rdata;
    device_err[d]    = err;
  endtask

  task automatic idle_all;
    for (int h = 0; h < 2; h++) host_drive(h, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int d = 0; d < 3; d++) dev_drive(d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every presented rvalid must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (rvalid_v != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: got rvalid=%b expected none", rvalid_v);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rvalid", {30'h0, rvalid_v}, 32'h1 << e.host);
          check("rsp_rdata", host_rdata[e.host], e.rdata);
          check("rsp_err", {31'h0, host_err[e.host]}, {31'h0, e.err});
          check("rsp_other_rdata", host_rdata[1 - e.host], 32'h0);
        end
      end else begin
        check("idle_err", {30'h0, err_v}, 32'h0);
      end
    end
  end

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    rst_n = 1'b0;
    idle_all();
    dev_drive(0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (2) step();
    check("rst_gnt", {30'h0, gnt_v}, 32'h0);
    check("rst_dreq", {29'h0, dreq_v}, 32'h0);
    check("rst_rvalid", {30'h0, rvalid_v}, 32'h0);
    check("rst_rdata", host_rdata[0], 32'h0);
    check("rst_dev_addr", device_addr[0], 32'h0);
    dev_drive(0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step();

    // Read 0x100004 -> device 0
    host_drive(0, 1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    #1;
    check("rd0_gnt", {30'h0, gnt_v}, 32'h1);
    check("rd0_dreq", {29'h0, dreq_v}, 32'h1);
    check("rd0_addr", device_addr[0], 32'h0010_0004);
    check("rd0_addr_bcast", device_addr[2], 32'h0010_0004);
    push_rsp(0, 32'hDEAD_BEEF, 1'b0);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    dev_drive(0, 1'b0, 32'h0, 1'b0);

    // Write 0x20000 -> device 1
    host_drive(0, 1'b1, 32'h0002_0000, 1'b1, 4'hF, 32'h41);
    #1;
    check("wr1_dreq", {29'h0, dreq_v}, 32'h2);
    check("wr1_we", {31'h0, device_we[1]}, 32'h1);
    check("wr1_be", {28'h0, device_be[1]}, 32'hF);
    check("wr1_wdata", device_wdata[1], 32'h41);
    check("wr1_addr", device_addr[1], 32'h0002_0000);
    push_rsp(0, 32'h0, 1'b0);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(1, 1'b1, 32'h0, 1'b0);
    step();
    dev_drive(1, 1'b0, 32'h0, 1'b0);
    check("idle_dev_addr", device_addr[1], 32'h0);

    // Unmapped 0x40000
    host_drive(0, 1'b1, 32'h0004_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check("unm_gnt", {30'h0, gnt_v}, 32'h1);
    check("unm_dreq", {29'h0, dreq_v}, 32'h0);
    push_rsp(0, 32'h0, 1'b1);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();

    // Device 2 error on read of 0x30008
    host_drive(0, 1'b1, 32'h0003_0008, 1'b0, 4'hF, 32'h0);
    #1;
    check("err2_dreq", {29'h0, dreq_v}, 32'h4);
    push_rsp(0, 32'h0000_0BAD, 1'b1);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(2, 1'b1, 32'h0000_0BAD, 1'b1);
    step();
    dev_drive(2, 1'b0, 32'h0, 1'b0);

    // Back-to-back: 0x100000 (dev0) then 0x30000 (dev2)
    host_drive(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check("b2b_a_dreq", {29'h0, dreq_v}, 32'h1);
    push_rsp(0, 32'h1111_1111, 1'b0);
    step();
    host_drive(0, 1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    dev_drive(0, 1'b1, 32'h1111_1111, 1'b0);
    #1;
    check("b2b_b_dreq", {29'h0, dreq_v}, 32'h4);
    push_rsp(0, 32'h2222_2222, 1'b0);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(0, 1'b0, 32'h0, 1'b0);
    dev_drive(2, 1'b1, 32'h2222_2222, 1'b0);
    step();
    dev_drive(2, 1'b0, 32'h0, 1'b0);

    // Two hosts contend: host0 wins, host1 follows once host0 drops
    host_drive(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    host_drive(1, 1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check("arb_gnt_h0", {30'h0, gnt_v}, 32'h1);
    check("arb_dreq_h0", {29'h0, dreq_v}, 32'h1);
    check("arb_addr_h0", device_addr[1], 32'h0010_0000);
    push_rsp(0, 32'hAAAA_0000, 1'b0);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(0, 1'b1, 32'hAAAA_0000, 1'b0);
    #1;
    check("arb_gnt_h1", {30'h0, gnt_v}, 32'h2);
    check("arb_dreq_h1", {29'h0, dreq_v}, 32'h4);
    check("arb_addr_h1", device_addr[0], 32'h0003_0000);
    push_rsp(1, 32'h0000_5555, 1'b0);
    step();
    host_drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dev_drive(0, 1'b0, 32'h0, 1'b0);
    dev_drive(2, 1'b1, 32'h0000_5555, 1'b0);
    step();
    dev_drive(2, 1'b0, 32'h0, 1'b0);

    // Reset while a response is pending suppresses it
    host_drive(0, 1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    #1;
    check("rstx_gnt", {30'h0, gnt_v}, 32'h1);
    step();
    host_drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    dev_drive(0, 1'b1, 32'h1234_5678, 1'b0);
    #1;
    check("rstx_suppress", {30'h0, rvalid_v}, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rstx_after", {30'h0, rvalid_v}, 32'h0);
    step();
    dev_drive(0, 1'b0, 32'h0, 1'b0);
    repeat (2) step();

    check("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
